// File: rtl/pc_stack_n_pkg.sv
// ============================================================================
// Module  : pc_pkg
// Brief   : Shared command encoding, priority decode and PC successor helper
//           for pc_stack_n. Optional macro: PC_STACK_SAT_EN (saturating step).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_pkg;

    typedef enum logic [2:0] {
        CMD_HOLD = 3'd0,
        CMD_INC  = 3'd1,
        CMD_LOAD = 3'd2,
        CMD_CALL = 3'd3,
        CMD_RET  = 3'd4
    } pc_cmd_e;

    // Widest PC the helper below can represent.
    localparam int unsigned PC_MAX_WIDTH = 64;

    function automatic pc_cmd_e pc_decode(
        input logic ret,
        input logic call,
        input logic load,
        input logic inc
    );
        pc_cmd_e cmd;
        if (ret) begin
            cmd = CMD_RET;
        end else if (call) begin
            cmd = CMD_CALL;
        end else if (load) begin
            cmd = CMD_LOAD;
        end else if (inc) begin
            cmd = CMD_INC;
        end else begin
            cmd = CMD_HOLD;
        end
        return cmd;
    endfunction

    // Callers truncate the result back to their own width.
    function automatic logic [63:0] pc_next_inc(
        input logic [63:0] pc,
        input logic [63:0] step,
        input int unsigned width
    );
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, pc} + {1'b0, step};
        lim = (65'd1 << width) - 65'd1;
`ifdef PC_STACK_SAT_EN
        if (sum > lim) begin
            sum = lim;
        end
`else
        sum = sum & lim;
`endif
        return sum[63:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_stack_n_if.sv
// ============================================================================
// Module  : pc_stack_n_if
// Brief   : Command and status bundle between the fetch controller (master)
//           and the program counter / return stack (slave).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_stack_n_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int SPW = $clog2(DEPTH + 1);

    logic             inc;
    logic             load;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] addr;
    logic             err_clr;
    logic [WIDTH-1:0] out;
    logic [SPW-1:0]   sp;
    logic             empty;
    logic             full;
    logic             ovf_err;
    logic             unf_err;

    modport master (
        output inc, load, call, ret, addr, err_clr,
        input  out, sp, empty, full, ovf_err, unf_err
    );

    modport slave (
        input  inc, load, call, ret, addr, err_clr,
        output out, sp, empty, full, ovf_err, unf_err
    );

endinterface

`default_nettype wire

// File: rtl/pc_stack_n_lifo.sv
// ============================================================================
// Module  : lifo_stack
// Brief   : Return-address LIFO: storage plus occupancy pointer. Storage is
//           not reset; only the pointer is.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lifo_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       push_i,
    input  wire logic                       pop_i,
    input  wire logic [WIDTH-1:0]           din_i,
    output logic      [WIDTH-1:0]           dout_o,
    output logic      [$clog2(DEPTH+1)-1:0] sp_o,
    output logic                            full_o,
    output logic                            empty_o
);
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [SPW-1:0]   sp_q;
    logic [SPW-1:0]   sp_d;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_full    = (sp_q == SPW'(DEPTH));
    assign w_empty   = (sp_q == '0);
    assign w_do_push = push_i & ~w_full;
    assign w_do_pop  = pop_i & ~w_empty & ~push_i;
    assign w_wr_idx  = AW'(sp_q);
    assign w_rd_idx  = AW'(sp_q - SPW'(1));

    always_comb begin
        sp_d = sp_q;
        if (w_do_push) begin
            sp_d = sp_q + SPW'(1);
        end else if (w_do_pop) begin
            sp_d = sp_q - SPW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[w_wr_idx] <= din_i;
        end
    end

    // Guarded read keeps an out-of-range index from ever reaching dout.
    assign dout_o  = w_empty ? '0 : mem_q[w_rd_idx];
    assign sp_o    = sp_q;
    assign full_o  = w_full;
    assign empty_o = w_empty;

endmodule

`default_nettype wire

// File: rtl/pc_stack_n.sv
// ============================================================================
// Module  : pc_stack_n
// Brief   : Program counter with hold/step/jump/call/return and a return-
//           address stack. Optional macro: PC_STACK_SAT_EN (saturating step).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_stack_n
    import pc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int STEP  = 1
) (
    input wire logic  clk,
    input wire logic  rst,
    pc_stack_n_if.slave bus_if
);
    localparam int          SPW    = $clog2(DEPTH + 1);
    localparam logic [63:0] c_STEP = 64'(STEP);

    pc_cmd_e          w_cmd;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             unf_q;
    logic             unf_d;
    logic [WIDTH-1:0] w_pc_inc;
    logic [WIDTH-1:0] w_stk_dout;
    logic [SPW-1:0]   w_sp;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    assign w_cmd    = pc_decode(bus_if.ret, bus_if.call, bus_if.load, bus_if.inc);
    // Shared by inc and by the return address pushed on call.
    assign w_pc_inc = WIDTH'(pc_next_inc(64'(pc_q), c_STEP, unsigned'(WIDTH)));

    always_comb begin
        pc_d   = pc_q;
        w_push = 1'b0;
        w_pop  = 1'b0;
        ovf_d  = ovf_q & ~bus_if.err_clr;
        unf_d  = unf_q & ~bus_if.err_clr;
        case (w_cmd)
            CMD_INC: begin
                pc_d = w_pc_inc;
            end
            CMD_LOAD: begin
                pc_d = bus_if.addr;
            end
            CMD_CALL: begin
                if (w_full) begin
                    ovf_d = 1'b1;
                end else begin
                    w_push = 1'b1;
                    pc_d   = bus_if.addr;
                end
            end
            CMD_RET: begin
                if (w_empty) begin
                    unf_d = 1'b1;
                end else begin
                    w_pop = 1'b1;
                    pc_d  = w_stk_dout;
                end
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    lifo_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .din_i   (w_pc_inc),
        .dout_o  (w_stk_dout),
        .sp_o    (w_sp),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign bus_if.out     = pc_q;
    assign bus_if.sp      = w_sp;
    assign bus_if.empty   = w_empty;
    assign bus_if.full    = w_full;
    assign bus_if.ovf_err = ovf_q;
    assign bus_if.unf_err = unf_q;

endmodule

`default_nettype wire
